// File: rtl/sfx_pkg.sv
// Shared types and elaboration-time helpers for the sound-effect player.
package sfx_pkg;

  // Per-channel playback state.
  typedef enum logic {
    StIdle,
    StPlay
  } ch_state_e;

  // Clock cycles per duration tick (TICK_DIV = CLK_HZ / TICK_HZ).
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Mixer accumulator width: room for CHANNELS full-scale volumes plus a guard bit.
  function automatic int unsigned sum_width(input int unsigned pwm_bits,
                                            input int unsigned channels);
    return pwm_bits + $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/sfx_channel.sv
// One square-wave effect channel: start/retrigger/abort FSM, tone divider,
// tick-based duration countdown and latched volume.
module sfx_channel
  import sfx_pkg::*;
#(
  parameter int unsigned DIV_W    = 20,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic [DIV_W-1:0]    half_period,
  input  logic [DUR_W-1:0]    duration,
  input  logic [PWM_BITS-1:0] volume,
  output logic                busy,
  output logic                done,
  output logic                level,
  output logic [PWM_BITS-1:0] vol
);

  ch_state_e           state_q;
  logic [DIV_W-1:0]    hp_q;
  logic [DIV_W-1:0]    div_q;
  logic [DUR_W-1:0]    rem_q;
  logic [PWM_BITS-1:0] vol_q;
  logic                sq_q;
  logic                done_q;
  logic                load;

  // A start with zero duration never loads; in PLAY it aborts instead.
  assign load = start && (duration != '0);

  // Channel FSM with tone divider and duration countdown; start wins over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hp_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      vol_q   <= '0;
      sq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q <= StPlay;
        hp_q    <= half_period;
        rem_q   <= duration;
        vol_q   <= volume;
        div_q   <= '0;
        sq_q    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StPlay: begin
            if (start) begin
              state_q <= StIdle;
            end else begin
              if (hp_q != '0) begin
                if (div_q == hp_q - DIV_W'(1)) begin
                  div_q <= '0;
                  sq_q  <= ~sq_q;
                end else begin
                  div_q <= div_q + DIV_W'(1);
                end
              end
              if (tick) begin
                rem_q <= rem_q - DUR_W'(1);
                if (rem_q == DUR_W'(1)) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy  = (state_q == StPlay);
  assign done  = done_q;
  // A zero half-period keeps the channel silent while it still times out.
  assign level = busy && sq_q && (hp_q != '0);
  assign vol   = vol_q;

endmodule

// File: rtl/sfx_player.sv
// Multi-channel sound-effect player: tick prescaler, saturating mixer, glitch-free
// PWM output and amplifier enable around CHANNELS sfx_channel instances.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned DIV_W    = 20,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned PWM_BITS = 8,
  parameter logic        GAIN     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS*DIV_W-1:0]    half_period,
  input  logic [CHANNELS*DUR_W-1:0]    duration,
  input  logic [CHANNELS*PWM_BITS-1:0] volume,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          done,
  output logic                         a_out,
  output logic                         gain,
  output logic                         shut_down_n
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUM_W    = sum_width(PWM_BITS, CHANNELS);
  localparam logic [PWM_BITS-1:0] PwmMax = '1;

  logic [PRE_W-1:0]                   presc_q;
  logic                               tick;
  logic [CHANNELS-1:0]                level;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  vol;
  logic [SUM_W-1:0]                   sum;
  logic [PWM_BITS-1:0]                mix;
  logic [PWM_BITS-1:0]                pwm_q;
  logic [PWM_BITS-1:0]                sample_q;
  logic                               a_out_q;
  logic                               shut_q;

  // Free-running tick prescaler; tick is high for the last cycle of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (presc_q == PRE_W'(TICK_DIV - 1)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sfx_channel #(
      .DIV_W   (DIV_W),
      .DUR_W   (DUR_W),
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .start      (start[i]),
      .half_period(half_period[i*DIV_W +: DIV_W]),
      .duration   (duration[i*DUR_W +: DUR_W]),
      .volume     (volume[i*PWM_BITS +: PWM_BITS]),
      .busy       (busy[i]),
      .done       (done[i]),
      .level      (level[i]),
      .vol        (vol[i])
    );
  end

  // Saturating sum of the volumes of all channels currently driving a high level.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (level[i]) begin
        sum = sum + SUM_W'(vol[i]);
      end
    end
    mix = (sum > {{(SUM_W - PWM_BITS){1'b0}}, PwmMax}) ? PwmMax : sum[PWM_BITS-1:0];
  end

  // PWM counter; the sample is only reloaded at counter zero to avoid mid-period glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q    <= '0;
      sample_q <= '0;
      a_out_q  <= 1'b0;
    end else begin
      pwm_q   <= pwm_q + PWM_BITS'(1);
      a_out_q <= (pwm_q < sample_q);
      if (pwm_q == '0) begin
        sample_q <= mix;
      end
    end
  end

  // Amplifier stays enabled while any channel plays, one cycle behind busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shut_q <= 1'b0;
    end else begin
      shut_q <= |busy;
    end
  end

  assign a_out       = a_out_q;
  assign shut_down_n = shut_q;
  assign gain        = GAIN;

endmodule

// File: tb/tb_sfx_player.sv
// Self-checking bench for sfx_player: directed effect scenarios followed by random
// triggers, compared every cycle against an edge-indexed behavioural model.
module tb_sfx_player;

  localparam int unsigned CH    = 2;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned DUR_W = 8;
  localparam int unsigned PB    = 4;
  localparam int TDIV = 10;   // 10_000 Hz clock / 1000 Hz tick
  localparam int PER  = 16;   // 2**PB
  localparam int VMAX = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [CH-1:0]        start = '0;
  logic [CH*DIV_W-1:0]  half_period = '0;
  logic [CH*DUR_W-1:0]  duration = '0;
  logic [CH*PB-1:0]     volume = '0;
  logic [CH-1:0]        busy;
  logic [CH-1:0]        done;
  logic                 a_out;
  logic                 gain;
  logic                 shut_down_n;

  sfx_player #(
    .CHANNELS(CH),
    .CLK_HZ  (10_000),
    .TICK_HZ (1000),
    .DIV_W   (DIV_W),
    .DUR_W   (DUR_W),
    .PWM_BITS(PB),
    .GAIN    (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .half_period(half_period),
    .duration   (duration),
    .volume     (volume),
    .busy       (busy),
    .done       (done),
    .a_out      (a_out),
    .gain       (gain),
    .shut_down_n(shut_down_n)
  );

  always #5 clk = ~clk;

  // Model: k counts rising edges since reset release; ticks land on edges k % 10 == 0,
  // PWM counter before edge k is (k-1) % 16. Each channel is described by its start
  // edge, settings and the edge on which it ends.
  int k;
  bit act   [CH];
  int ks    [CH];
  int kend  [CH];
  int mhp   [CH];
  int mvol  [CH];
  bit mdone [CH];
  int sample_m;
  bit a_m;
  bit shut_m;

  bit st_in  [CH];
  int hp_in  [CH];
  int dur_in [CH];
  int vol_in [CH];

  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";

  function automatic bit lvl(input int c);
    if (!act[c] || mhp[c] == 0) return 1'b0;
    return (((k - ks[c]) / mhp[c]) % 2) == 0;
  endfunction

  function automatic int mix_now();
    int s;
    s = 0;
    for (int c = 0; c < CH; c++) if (lvl(c)) s += mvol[c];
    return (s > VMAX) ? VMAX : s;
  endfunction

  function automatic bit any_busy();
    bit b;
    b = 1'b0;
    for (int c = 0; c < CH; c++) b |= act[c];
    return b;
  endfunction

  function automatic logic [CH-1:0] busy_vec();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = act[c];
    return v;
  endfunction

  function automatic logic [CH-1:0] done_vec();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = mdone[c];
    return v;
  endfunction

  task automatic reset_model();
    k = 0;
    sample_m = 0;
    a_m = 1'b0;
    shut_m = 1'b0;
    for (int c = 0; c < CH; c++) begin
      act[c] = 1'b0;
      mdone[c] = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    logic [2*CH+2:0] obs;
    logic [2*CH+2:0] exp;
    obs = {busy, done, a_out, shut_down_n, gain};
    exp = {busy_vec(), done_vec(), a_m, shut_m, 1'b1};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s k=%0d {busy,done,a_out,shut_down_n,gain} observed=%b expected=%b",
             tag, k, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input int hp, input int dur, input int vl);
    st_in[c]  = 1'b1;
    hp_in[c]  = hp;
    dur_in[c] = dur;
    vol_in[c] = vl;
  endtask

  // Apply the pending inputs across one rising edge, advance the model, then compare.
  task automatic step();
    int mix_prev;
    bit busy_prev;
    for (int c = 0; c < CH; c++) begin
      half_period[c*DIV_W +: DIV_W] = DIV_W'(hp_in[c]);
      duration[c*DUR_W +: DUR_W]    = DUR_W'(dur_in[c]);
      volume[c*PB +: PB]            = PB'(vol_in[c]);
      start[c]                      = st_in[c];
    end
    mix_prev  = mix_now();
    busy_prev = any_busy();
    @(posedge clk);
    k++;
    a_m = ((k - 1) % PER) < sample_m;
    if ((k - 1) % PER == 0) sample_m = mix_prev;
    shut_m = busy_prev;
    for (int c = 0; c < CH; c++) begin
      mdone[c] = 1'b0;
      if (st_in[c]) begin
        if (dur_in[c] != 0) begin
          act[c]  = 1'b1;
          ks[c]   = k;
          mhp[c]  = hp_in[c];
          mvol[c] = vol_in[c];
          kend[c] = ((k / TDIV) + 1) * TDIV + (dur_in[c] - 1) * TDIV;
        end else begin
          act[c] = 1'b0;
        end
      end else if (act[c] && k == kend[c]) begin
        act[c]   = 1'b0;
        mdone[c] = 1'b1;
      end
    end
    #1;
    check(phase);
    for (int c = 0; c < CH; c++) st_in[c] = 1'b0;
    start = '0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Assert reset between edges, check outputs asynchronously, release on a falling edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    check("async_reset");
    repeat (2) @(negedge clk);
    check("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      st_in[c]  = 1'b0;
      hp_in[c]  = 0;
      dur_in[c] = 0;
      vol_in[c] = 0;
    end
    reset_model();
    #1 rst_n = 1'b0;
    #2 check("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    phase = "single";
    set_ch(0, 3, 5, 8);
    run(60);

    phase = "saturate";
    set_ch(0, 40, 5, 12);
    set_ch(1, 40, 5, 12);
    run(60);

    phase = "one_high";
    set_ch(0, 100, 5, 12);
    set_ch(1, 20, 5, 12);
    run(60);

    phase = "retrigger";
    set_ch(0, 2, 5, 6);
    run(25);
    set_ch(0, 2, 4, 6);
    run(60);

    phase = "zero_idle";
    set_ch(1, 5, 0, 9);
    run(15);

    phase = "abort";
    set_ch(1, 5, 5, 9);
    run(15);
    set_ch(1, 5, 0, 9);
    run(20);

    phase = "silent";
    set_ch(0, 0, 2, 15);
    run(30);

    phase = "reset_mid";
    set_ch(0, 3, 5, 10);
    set_ch(1, 4, 5, 7);
    run(15);
    pulse_reset();
    run(40);

    phase = "random";
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 29) == 0) begin
          set_ch(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 15)));
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
